// File: rtl/imem_access_arbiter.sv
// Instruction-RAM arbiter. A loader-only boot phase is followed by per-cycle sharing
// between fetch and loader, with a bounded loader burst so fetch is never starved.
module imem_access_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int LD_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_err,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  input  logic              ld_done,
  output logic              booting,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [0:0] ST_BOOT   = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;
  localparam logic [3:0] BURST_LIM = 4'(LD_BURST_MAX);

  logic [0:0]        state_q, state_d;
  logic [3:0]        burst_q, burst_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              f_rvalid_q, f_err_q, ld_rvalid_q;
  logic              fetch_bad;

  always_comb begin
    fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:ADDR_W+2] != '0);
  end

  // Loader has priority in RUN until it has won BURST_LIM cycles in a row over a waiting fetch.
  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    if (state_q == ST_BOOT) begin
      ld_gnt = ld_req;
    end else if (fetch_req && ld_req) begin
      if (burst_q == BURST_LIM) fetch_gnt = 1'b1;
      else                      ld_gnt    = 1'b1;
    end else begin
      fetch_gnt = fetch_req;
      ld_gnt    = ld_req;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (fetch_gnt) begin
      mem_en   = !fetch_bad;
      mem_addr = fetch_addr[ADDR_W+1:2];
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_BOOT && ld_done) state_d = ST_RUN;
  end

  always_comb begin
    burst_d = burst_q;
    if (state_q == ST_BOOT || !fetch_req || fetch_gnt) begin
      burst_d = '0;
    end else if (ld_gnt && burst_q != BURST_LIM) begin
      burst_d = burst_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      burst_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f_rvalid_q  <= 1'b0;
      f_err_q     <= 1'b0;
      ld_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      addr_q      <= mem_addr;
      wdata_q     <= mem_wdata;
      f_rvalid_q  <= fetch_gnt;
      f_err_q     <= fetch_gnt && fetch_bad;
      ld_rvalid_q <= ld_gnt && !ld_we;
    end
  end

  // A rejected fetch returns an all-zero word so the core sees a harmless value.
  assign fetch_rvalid = f_rvalid_q;
  assign fetch_err    = f_err_q;
  assign fetch_rdata  = (f_rvalid_q && !f_err_q) ? mem_rdata : '0;
  assign ld_rvalid    = ld_rvalid_q;
  assign booting      = (state_q == ST_BOOT);

endmodule
